// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port synchronous system RAM between the 6502
// core and a DMA requester. DMA wins a slot when it requests, but after
// MAX_BURST consecutive DMA slots the CPU gets exactly one slot. The CPU is
// stalled through cpu_rdy whenever DMA owns the slot.
// Optional build macro RAM_ARB_STATS_EN enables the stall_cnt counter;
// without it stall_cnt reads as zero.
module ram_arbiter #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned MAX_BURST = 4,
  parameter logic [7:0]  FILL      = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_ab,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_do,
  output logic [7:0]        cpu_di,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [15:0]       dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  logic        r_run;
  logic [7:0]  r_burst_cnt;
  logic        r_tag_cpu;
  logic        r_tag_dma_rd;
  logic        r_tag_oor;
  logic [7:0]  r_cpu_hold;
  logic [7:0]  r_dma_hold;

  logic        w_dma_own;
  logic [15:0] w_addr;
  logic        w_we;
  logic [7:0]  w_wdata;
  logic        w_in_range;
  logic [7:0]  w_rdata;

  // DMA owns the slot only once running and while its burst budget remains.
  assign w_dma_own = r_run & dma_req & (r_burst_cnt < LP_MAX_BURST);

  // Route the owner's address, write enable and write data to the RAM.
  always_comb begin
    w_addr  = cpu_ab;
    w_we    = cpu_we;
    w_wdata = cpu_do;
    if (w_dma_own) begin
      w_addr  = dma_addr;
      w_we    = dma_we;
      w_wdata = dma_wdata;
    end
  end

  assign w_in_range = (w_addr >> ADDR_W) == '0;

  assign dma_ack   = w_dma_own;
  assign cpu_rdy   = ~w_dma_own;
  assign mem_addr  = w_addr[ADDR_W-1:0];
  assign mem_wdata = w_wdata;
  // Gating with reset keeps the RAM untouched for the whole reset pulse,
  // even though the CPU nominally owns every slot while r_run is low.
  assign mem_we    = w_we & w_in_range & reset;

  // Run flag and burst length: count DMA slots, clear on any CPU slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run       <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_dma_own) begin
        if (r_burst_cnt != LP_MAX_BURST) begin
          r_burst_cnt <= r_burst_cnt + 8'd1;
        end
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  // Tag describing the slot whose read data arrives on mem_rdata next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_cpu    <= 1'b0;
      r_tag_dma_rd <= 1'b0;
      r_tag_oor    <= 1'b0;
    end else begin
      r_tag_cpu    <= ~w_dma_own;
      r_tag_dma_rd <= w_dma_own & ~w_we;
      r_tag_oor    <= ~w_in_range;
    end
  end

  assign w_rdata = r_tag_oor ? FILL : mem_rdata;

  // Hold registers keep the last returned byte for each requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_hold <= '0;
      r_dma_hold <= '0;
    end else begin
      if (r_tag_cpu) begin
        r_cpu_hold <= w_rdata;
      end
      if (r_tag_dma_rd) begin
        r_dma_hold <= w_rdata;
      end
    end
  end

  assign cpu_di     = r_tag_cpu ? w_rdata : r_cpu_hold;
  assign dma_rvalid = r_tag_dma_rd;
  assign dma_rdata  = r_tag_dma_rd ? w_rdata : r_dma_hold;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Count CPU stall cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_dma_own && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by random traffic,
// all checked against a slot-level reference model and a shadow memory.
module tb_ram_arbiter;

  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned MAX_BURST = 4;
  localparam logic [7:0]  FILL      = 8'hFF;
  localparam int unsigned DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       cpu_ab;
  logic              cpu_we;
  logic [7:0]        cpu_do;
  logic [7:0]        cpu_di;
  logic              cpu_rdy;
  logic              dma_req;
  logic              dma_we;
  logic [15:0]       dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_ack;
  logic              dma_rvalid;
  logic [7:0]        dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [15:0]       stall_cnt;

  ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .MAX_BURST(MAX_BURST),
    .FILL     (FILL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_ab    (cpu_ab),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .cpu_rdy   (cpu_rdy),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(int unsigned i);
    if (i == 32'h10) return 8'h5A;
    return 8'((i * 29) ^ (i >> 5) ^ 32'hC3);
  endfunction

  // Synchronous single-port RAM, read-first, one cycle read latency.
  logic [7:0]  ram [DEPTH];
  bit          ram_init_done = 1'b0;
  int unsigned wr_total = 0;
  int unsigned wr100_cnt = 0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[i] = init_byte(i);
      ram_init_done = 1'b1;
    end
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_total++;
      if (mem_addr == 13'h100) wr100_cnt++;
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [DEPTH];
  bit          m_run;
  int unsigned m_burst;
  bit          m_last_own;
  logic [7:0]  m_cpu_di;
  logic [7:0]  m_rdata;
  bit          m_rvalid;
  int unsigned m_stall;
  logic        s_ack;
  logic        s_mem_we;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_stall();
`ifdef RAM_ARB_STATS_EN
    return 16'(m_stall);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 16'($urandom_range(DEPTH, 16'hFFFF));
    return 16'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic model_reset();
    m_run      = 1'b0;
    m_burst    = 0;
    m_last_own = 1'b0;
    m_cpu_di   = 8'h00;
    m_rdata    = 8'h00;
    m_rvalid   = 1'b0;
    m_stall    = 0;
  endtask

  // One clock cycle: check at the falling edge, advance the model, return
  // 1 time unit after the next rising edge so the caller can drive inputs.
  task automatic step();
    bit          own;
    bit          wr;
    bit          inr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rdv;
    @(negedge clk);
    check_val("cpu_di", 32'(cpu_di), 32'(m_cpu_di));
    check_val("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
    check_val("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
    check_val("stall_cnt", 32'(stall_cnt), 32'(exp_stall()));
    own = m_run && dma_req && (m_burst < MAX_BURST);
    s_ack    = dma_ack;
    s_mem_we = mem_we;
    check_val("dma_ack", 32'(dma_ack), 32'(own));
    check_val("cpu_rdy", 32'(cpu_rdy), 32'(!own));
    a   = own ? dma_addr  : cpu_ab;
    wr  = own ? dma_we    : cpu_we;
    d   = own ? dma_wdata : cpu_do;
    inr = (32'(a) < DEPTH);
    check_val("mem_we", 32'(mem_we), 32'(wr && inr));
    check_val("mem_addr", 32'(mem_addr), 32'(a) % DEPTH);
    if (wr && inr) check_val("mem_wdata", 32'(mem_wdata), 32'(d));
    rdv = inr ? ref_mem[32'(a) % DEPTH] : FILL;
    if (own) begin
      m_rvalid = !wr;
      if (!wr) m_rdata = rdv;
      m_burst++;
      if (m_stall < 32'hFFFF) m_stall++;
    end else begin
      m_rvalid = 1'b0;
      m_cpu_di = rdv;
      m_burst  = 0;
    end
    if (wr && inr) ref_mem[32'(a) % DEPTH] = d;
    m_run      = 1'b1;
    m_last_own = own;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; returns just after a rising edge.
  task automatic apply_reset();
    int unsigned wr_snap;
    #2 reset = 1'b0;
    #1;
    check_val("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check_val("rst_dma_ack", 32'(dma_ack), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_rvalid", 32'(dma_rvalid), 32'd0);
    check_val("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    check_val("rst_cpu_di", 32'(cpu_di), 32'd0);
    check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    wr_snap = wr_total;
    repeat (2) @(posedge clk);
    check_val("rst_no_write", wr_total, wr_snap);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [11:0] pat;
    int unsigned acks;
    int unsigned cyc;
    int unsigned pct;
    logic [7:0]  ram0;
    int unsigned w100;

    reset     = 1'b0;
    cpu_ab    = 16'h0000;
    cpu_we    = 1'b0;
    cpu_do    = 8'h00;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Idle DMA, CPU read of 0x0010.
    cpu_ab = 16'h0010;
    step();
    check_val("t1_cpu_di", 32'(cpu_di), 32'h5A);
    check_val("t1_cpu_rdy", 32'(cpu_rdy), 32'd1);

    // Ten held DMA reads: expect DDDD C DDDD C DD.
    dma_req = 1'b1;
    dma_we  = 1'b0;
    pat  = '0;
    acks = 0;
    cyc  = 0;
    while (acks < 10 && cyc < 40) begin
      dma_addr = 16'(32'h20 + acks);
      step();
      pat = {pat[10:0], s_ack};
      if (s_ack) acks++;
      cyc++;
    end
    dma_req = 1'b0;
    check_val("burst_cycles", cyc, 32'd12);
    check_val("burst_pattern", 32'(pat), 32'b1111_0111_1011);
    step();

    // Simultaneous writes: DMA first, CPU write deferred and done once.
    w100      = wr100_cnt;
    cpu_ab    = 16'h0100;
    cpu_we    = 1'b1;
    cpu_do    = 8'h33;
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 16'h0200;
    dma_wdata = 8'h77;
    step();
    check_val("wr_dma_first", 32'(s_ack), 32'd1);
    dma_req = 1'b0;
    step();
    cpu_we = 1'b0;
    step();
    check_val("wr_ram200", 32'(ram[13'h200]), 32'h77);
    check_val("wr_ram100", 32'(ram[13'h100]), 32'h33);
    check_val("wr_100_once", wr100_cnt - w100, 32'd1);

    // Out-of-range CPU read and DMA write.
    ram0      = ram[0];
    cpu_ab    = 16'hE000;
    cpu_we    = 1'b0;
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 16'h4000;
    dma_wdata = 8'h99;
    step();
    check_val("oor_ack", 32'(s_ack), 32'd1);
    check_val("oor_mem_we", 32'(s_mem_we), 32'd0);
    dma_req = 1'b0;
    step();
    check_val("oor_cpu_di", 32'(cpu_di), 32'(FILL));
    check_val("oor_ram_kept", 32'(ram[0]), 32'(ram0));

    // DMA request held across reset: no ack until the second edge.
    cpu_ab   = 16'h0040;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 16'h0030;
    apply_reset();
    step();
    check_val("rst_first_ack", 32'(s_ack), 32'd0);
    step();
    check_val("rst_second_ack", 32'(s_ack), 32'd1);
    step();

    // Reset in the middle of a burst with a CPU write pending.
    cpu_ab = 16'h0300;
    cpu_we = 1'b1;
    cpu_do = 8'hAB;
    apply_reset();
    cpu_we = 1'b0;

    // Seven DMA slots after reset.
    acks = 0;
    cyc  = 0;
    while (acks < 7 && cyc < 30) begin
      step();
      if (s_ack) acks++;
      cyc++;
    end
    dma_req = 1'b0;
    check_val("stall_acks", acks, 32'd7);
    step();
`ifdef RAM_ARB_STATS_EN
    check_val("stall_cnt7", 32'(stall_cnt), 32'd7);
`else
    check_val("stall_cnt7", 32'(stall_cnt), 32'd0);
`endif

    // Random traffic at several DMA loads.
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 95 : (ph == 1) ? 60 : 25;
      for (int n = 0; n < 1500; n++) begin
        if (!m_last_own) begin
          cpu_ab = rand_addr();
          cpu_we = ($urandom_range(0, 3) == 0);
          cpu_do = 8'($urandom);
        end
        if (m_last_own || !dma_req) begin
          dma_req   = ($urandom_range(0, 99) < pct);
          dma_we    = 1'($urandom_range(0, 1));
          dma_addr  = rand_addr();
          dma_wdata = 8'($urandom);
        end
        if ($urandom_range(0, 599) == 0) apply_reset();
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous system RAM (1-cycle read latency) between the 6502 core and a secondary DMA requester, e.g. a loader or video fetch.
- Sits between the cpu instance, the RAM array and the DMA master.
- Stalls the CPU through its RDY input whenever the DMA owns the RAM slot.
- Bounds DMA bursts so the CPU is never starved.

Parameters:
ADDR_W, 13, RAM address width (RAM depth 2^ADDR_W bytes).
MAX_BURST, 4, max consecutive DMA slots before one CPU slot is forced; legal range 1..255.
FILL, 8'hFF, read data returned for addresses outside the RAM window.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cpu_ab  input  16  CPU address bus
cpu_we  input  1  CPU write enable
cpu_do  input  8  CPU write data
cpu_di  output  8  read data to CPU
cpu_rdy  output  1  CPU ready; 0 stalls the core
dma_req  input  1  DMA access request; held until acked
dma_we  input  1  DMA write (1) / read (0)
dma_addr  input  16  DMA address
dma_wdata  input  8  DMA write data
dma_ack  output  1  DMA access performed this cycle
dma_rvalid  output  1  dma_rdata valid (cycle after a DMA read ack)
dma_rdata  output  8  DMA read data
mem_addr  output  ADDR_W  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  8  RAM write data
mem_rdata  input  8  RAM read data, valid the cycle after the address
stall_cnt  output  16  CPU stall-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0, all registers clear immediately.
- Reset values: cpu_rdy=1, dma_ack=0, dma_rvalid=0, dma_rdata=0, cpu_di=0, stall_cnt=0, burst_cnt=0, run=0.
- run flag: set on the first rising clk after reset deasserts. While run=0, every slot belongs to the CPU.
- Slot owner (combinational, every cycle):
  - DMA owns the slot when run=1, dma_req=1 and burst_cnt<MAX_BURST.
  - Otherwise the CPU owns the slot.
- State (burst_cnt):
  - DMA slot: burst_cnt+1, saturating at MAX_BURST.
  - CPU slot: burst_cnt cleared to 0.
  - Result: at most MAX_BURST back-to-back DMA slots, then exactly one CPU slot, then DMA may resume.
- Outputs per slot:
  - dma_ack equals DMA ownership.
  - cpu_rdy is the inverse of DMA ownership.
  - mem_addr, mem_we and mem_wdata are muxed combinationally from the owner.
- Window decode: an address is in range iff bits [15:ADDR_W] are all 0.
  - Out-of-range write: mem_we forced to 0; the access still completes and is acked.
  - Out-of-range read: returns FILL.
- Writes:
  - mem_we=1 only for an owner write to an in-range address.
  - A CPU write in a stalled cycle is not performed. The core holds AB/DO/WE while RDY=0, so the write executes in its next CPU slot (never twice).
- Read return: a registered tag holds last owner, read flag and out-of-range flag.
  - Cycle after a DMA read slot: dma_rvalid=1, dma_rdata = mem_rdata (or FILL). Otherwise dma_rvalid=0 and dma_rdata holds its last value.
  - Cycle after a CPU slot: cpu_di = mem_rdata (or FILL), and the value is also captured into a hold register.
  - All other cycles: cpu_di = hold register, stable across the whole stall.
- DMA writes produce no rvalid.
- DMA request withdrawn (dma_req low) mid-burst: the CPU gets the slot immediately and burst_cnt clears.
- Reset mid-burst: the pending rvalid is lost, cpu_rdy returns to 1 asynchronously, and no RAM write occurs while reset=0.

Optional Feature:
RAM_ARB_STATS_EN:
- Defined: stall_cnt increments on every cycle with cpu_rdy=0, saturating at 16'hFFFF; cleared only by reset.
- Undefined: stall_cnt tied to 16'h0000 and no counter logic is built.
- The port is present in both builds.

Test Plan:
- Reset then idle DMA, CPU reads 0x0010 (RAM[0x10]=0x5A) -> cpu_rdy stays 1; cpu_di=0x5A one cycle after the address.
- dma_req held for 10 reads with MAX_BURST=4 -> ack pattern DDDD C DDDD C DD; cpu_rdy low exactly in D cycles; dma_rvalid one cycle after each ack; cpu_di held stable through each stall.
- CPU writes 0x33 to 0x0100 in the same cycle DMA writes 0x77 to 0x0200 -> DMA acked first, CPU write deferred to the next slot; final RAM[0x200]=0x77, RAM[0x100]=0x33, RAM[0x100] written exactly once.
- CPU read at 0xE000 and DMA write at 0x4000 -> cpu_di=0xFF, mem_we=0, dma_ack=1.
- dma_req=1 asserted during reset and reset deasserted -> no dma_ack until the second edge after deassert; reset asserted mid-burst forces cpu_rdy=1 and dma_ack=0 asynchronously.
- With RAM_ARB_STATS_EN, 7 DMA slots -> stall_cnt=7; without the macro -> stall_cnt=0.
